// File: rtl/chan_write_arbiter_if.sv
// Write-port bundle between writer threads, the arbiter and the channel FIFO.
// master drives requests and FIFO status; slave is the arbiter side.
interface chan_write_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 2
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] wr_data;
  logic [NUM_REQ-1:0]            ack;
  logic                          fifo_full;
  logic                          fifo_wr;
  logic [DATA_WIDTH-1:0]         fifo_wdata;
  logic [ID_WIDTH-1:0]           grant_id;
  logic                          busy;

  modport master (
    output req, wr_data, fifo_full,
    input  ack, fifo_wr, fifo_wdata, grant_id, busy
  );

  modport slave (
    input  req, wr_data, fifo_full,
    output ack, fifo_wr, fifo_wdata, grant_id, busy
  );
endinterface

// File: rtl/chan_write_arbiter.sv
// Round-robin arbiter sharing one channel FIFO write port among writers.
// Optional write/stall counters enabled by CHAN_ARB_STATS_EN.
module chan_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 2
) (
  input  logic clock,
  input  logic rst,
  chan_write_arbiter_if.slave bus
`ifdef CHAN_ARB_STATS_EN
  ,
  output logic [31:0] stat_writes,
  output logic [31:0] stat_stalls
`endif
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                  state;
  logic [ID_WIDTH-1:0]     gid;
  logic [ID_WIDTH-1:0]     rr_ptr;
  logic [DATA_WIDTH-1:0]   data_q;

  logic                    wr;
  logic [NUM_REQ-1:0]      ack_v;
  logic [NUM_REQ-1:0]      elig;
  logic [ID_WIDTH-1:0]     start;
  logic [2*NUM_REQ-1:0]    dbl;
  logic [NUM_REQ-1:0]      rot;
  logic                    found;
  logic [ID_WIDTH-1:0]     pick_id;
  logic [DATA_WIDTH-1:0]   pick_data;

  assign wr = (state == GRANT) && !bus.fifo_full;

  always_comb begin
    ack_v = '0;
    if (wr) ack_v = NUM_REQ'(1) << gid;
  end

  // The requester written this cycle is masked so others get the next slot
  assign elig = bus.req & ~ack_v;

  assign start = (rr_ptr == ID_WIDTH'(NUM_REQ - 1)) ?
                 '0 : rr_ptr + 1'b1;
  assign dbl   = {elig, elig};
  assign rot   = NUM_REQ'(dbl >> start);

  always_comb begin
    logic [NUM_REQ-1:0] sh;
    int p;
    found   = 1'b0;
    pick_id = '0;
    sh      = '0;
    p       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sh = rot >> i;
      if (!found && sh[0]) begin
        found = 1'b1;
        p = int'(start) + i;
        if (p >= NUM_REQ) p = p - NUM_REQ;
        pick_id = ID_WIDTH'(p);
      end
    end
  end

  assign pick_data =
    DATA_WIDTH'(bus.wr_data >> (pick_id * DATA_WIDTH));

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      gid    <= '0;
      data_q <= '0;
      rr_ptr <= ID_WIDTH'(NUM_REQ - 1);
    end else if (state == IDLE || wr) begin
      if (found) begin
        state  <= GRANT;
        gid    <= pick_id;
        data_q <= pick_data;
        rr_ptr <= pick_id;
      end else begin
        state  <= IDLE;
      end
    end
  end

  assign bus.fifo_wr    = wr;
  assign bus.ack        = ack_v;
  assign bus.fifo_wdata = data_q;
  assign bus.grant_id   = gid;
  assign bus.busy       = (state == GRANT);

`ifdef CHAN_ARB_STATS_EN
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      stat_writes <= '0;
      stat_stalls <= '0;
    end else begin
      if (wr) stat_writes <= stat_writes + 32'd1;
      if (state == GRANT && bus.fifo_full)
        stat_stalls <= stat_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_chan_write_arbiter.sv
// Scoreboard bench for chan_write_arbiter: directed scenarios push
// expected writes; a negedge monitor pops and compares each FIFO write.
module tb_chan_write_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  chan_write_arbiter_if #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)
  ) bus ();

`ifdef CHAN_ARB_STATS_EN
  logic [31:0] stat_writes;
  logic [31:0] stat_stalls;
`endif

  chan_write_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)
  ) dut (
    .clock(clk),
    .rst(rst),
    .bus(bus)
`ifdef CHAN_ARB_STATS_EN
    ,
    .stat_writes(stat_writes),
    .stat_stalls(stat_stalls)
`endif
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [N-1:0]  ack;
    logic [IW-1:0] id;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  logic [DW-1:0] dat [N];
  bit auto_upd = 1'b0;

  assign bus.wr_data = {dat[3], dat[2], dat[1], dat[0]};

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.fifo_wr) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: id %0d data %0h expected none",
                 bus.grant_id, bus.fifo_wdata);
      end else begin
        e = sb.pop_front();
        chk("wr_data", 64'(bus.fifo_wdata), 64'(e.data));
        chk("wr_ack", 64'(bus.ack), 64'(e.ack));
        chk("wr_id", 64'(bus.grant_id), 64'(e.id));
      end
    end else begin
      chk("idle_ack", 64'(bus.ack), 64'd0);
    end
  end

  task automatic tick();
    logic [N-1:0] a;
    @(negedge clk);
    a = bus.ack;
    @(posedge clk);
    #1;
    if (auto_upd)
      for (int i = 0; i < N; i++)
        if (a[i]) dat[i] = dat[i] + 32'h10;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;
    bus.fifo_full = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic [DW-1:0] d, input int id);
    exp_t e;
    e.data = d;
    e.ack = N'(1) << id;
    e.id = IW'(id);
    sb.push_back(e);
  endtask

  task automatic push_contention();
    for (int k = 0; k < 8; k++)
      push(32'h10 + 32'h10 * (k / 4) + k % 4, k % 4);
  endtask

  task automatic drain(input string nm);
    chk(nm, 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  initial begin
    rst = 1'b1;
    bus.req = '0;
    bus.fifo_full = 1'b0;
    for (int i = 0; i < N; i++) dat[i] = '0;
    tick();
    tick();
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_wr", 64'(bus.fifo_wr), 64'd0);
    chk("rst_wdata", 64'(bus.fifo_wdata), 64'd0);
    chk("rst_id", 64'(bus.grant_id), 64'd0);
    rst = 1'b0;

    // single requester, one-cycle request
    dat[0] = 32'hA5;
    bus.req = 4'b0001;
    push(32'hA5, 0);
    tick();
    chk("single_busy", 64'(bus.busy), 64'd1);
    chk("single_id", 64'(bus.grant_id), 64'd0);
    bus.req = '0;
    tick();
    chk("single_idle", 64'(bus.busy), 64'd0);
    tick();
    drain("single_drain");

    // full contention
    do_reset();
    dat[0] = 32'h10; dat[1] = 32'h11;
    dat[2] = 32'h12; dat[3] = 32'h13;
    auto_upd = 1'b1;
    push_contention();
    bus.req = 4'b1111;
    repeat (8) tick();
    bus.req = '0;
    tick();
    tick();
    auto_upd = 1'b0;
    drain("cont_drain");

    // backpressure while granted to requester 2
    dat[2] = 32'h77;
    bus.req = 4'b0100;
    bus.fifo_full = 1'b1;
    push(32'h77, 2);
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("bp_id", 64'(bus.grant_id), 64'd2);
      chk("bp_wr", 64'(bus.fifo_wr), 64'd0);
      chk("bp_busy", 64'(bus.busy), 64'd1);
      tick();
    end
    bus.fifo_full = 1'b0;
    tick();
    bus.req = '0;
    tick();
    drain("bp_drain");

    // lone requester held: masked every other cycle
    dat[1] = 32'h55;
    bus.req = 4'b0010;
    for (int k = 0; k < 3; k++) push(32'h55, 1);
    for (int c = 1; c <= 5; c++) begin
      tick();
      chk("mask_busy", 64'(bus.busy), 64'(c % 2));
    end
    tick();
    bus.req = '0;
    tick();
    drain("mask_drain");

    // async reset while stalled in GRANT
    dat[3] = 32'h99;
    bus.req = 4'b1000;
    bus.fifo_full = 1'b1;
    tick();
    chk("ar_pre_busy", 64'(bus.busy), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_busy", 64'(bus.busy), 64'd0);
    chk("ar_wr", 64'(bus.fifo_wr), 64'd0);
    chk("ar_ack", 64'(bus.ack), 64'd0);
    chk("ar_wdata", 64'(bus.fifo_wdata), 64'd0);
    chk("ar_id", 64'(bus.grant_id), 64'd0);
    tick();
    rst = 1'b0;
    bus.fifo_full = 1'b0;
    dat[0] = 32'h40; dat[1] = 32'h41;
    dat[2] = 32'h42; dat[3] = 32'h43;
    bus.req = 4'b1111;
    push(32'h40, 0);
    tick();
    chk("ar_first_id", 64'(bus.grant_id), 64'd0);
    bus.req = '0;
    tick();
    tick();
    drain("ar_drain");

    // contention with three stall cycles
    do_reset();
    dat[0] = 32'h10; dat[1] = 32'h11;
    dat[2] = 32'h12; dat[3] = 32'h13;
    auto_upd = 1'b1;
    push_contention();
    bus.req = 4'b1111;
    repeat (3) tick();
    chk("stall_id", 64'(bus.grant_id), 64'd2);
    bus.fifo_full = 1'b1;
    repeat (3) tick();
    bus.fifo_full = 1'b0;
    repeat (5) tick();
    bus.req = '0;
    tick();
    tick();
    auto_upd = 1'b0;
    drain("stall_drain");
`ifdef CHAN_ARB_STATS_EN
    chk("stat_writes", 64'(stat_writes), 64'd8);
    chk("stat_stalls", 64'(stat_stalls), 64'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
